// File: rtl/cpu_sequencer.sv
// cpu_sequencer: program FIFO plus issue FSM that drains command words into a
// simple multi-cycle CPU and captures each ALU result from register 0.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; FIFO may be filled
// ISSUE   | cpu_ce high, head word driven on cpu_*, head popped
// WAIT1   | CPU in OPERATION
// WAIT2   | CPU in WAIT, result settling in register 0
// CAPTURE | result registered into res_data, res_valid high
// DONE    | one-cycle done pulse, then back to IDLE
module cpu_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [17:0]       prog_wdata,
  output logic              prog_full,
  output logic [ADDR_W:0]   prog_count,
  output logic              overflow,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        cpu_data_in,
  output logic [6:0]        cpu_opcode,
  output logic              cpu_cin,
  output logic              cpu_cout,
  output logic              cpu_load,
  output logic              cpu_ce,
  input  logic [7:0]        cpu_data_out,
  output logic              res_valid,
  output logic [7:0]        res_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT1   = 3'd2,
    S_WAIT2   = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [17:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic [ADDR_W:0]   remain;
  logic [ADDR_W:0]   avail;
  logic              overflow_q;
  logic              full;
  logic              wr_ok;
  logic              pop;
  logic [17:0]       head_next;

  state_t            state_q;
  state_t            state_d;
  logic [17:0]       issue_q;
  logic              ce_q;
  logic              busy_q;
  logic              done_q;
  logic              res_valid_q;
  logic [7:0]        res_data_q;

  assign full  = (count_q == FULL_CNT);
  assign wr_ok = prog_we && !full;
  assign pop   = (state_q == S_ISSUE);

  // Occupancy bookkeeping and the word that would be at the head next cycle.
  // A word written in the same cycle the FSM looks for more work is counted
  // and forwarded straight from prog_wdata, so late pushes join the run.
  always_comb begin
    count_d   = count_q + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, pop};
    rd_next   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    remain    = count_q - {{ADDR_W{1'b0}}, pop};
    avail     = remain + {{ADDR_W{1'b0}}, wr_ok};
    head_next = (remain == '0) ? prog_wdata : mem_q[rd_next];
  end

  // FIFO pointers, count and sticky overflow; writes while full are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      if (prog_we && full) overflow_q <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care after reset since count gates reads
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= prog_wdata;
  end

  // Next-state decode for the issue sequencer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (count_q != '0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        if (issue_q[17]) state_d = (avail != '0) ? S_ISSUE : S_DONE;
        else             state_d = S_WAIT1;
      end
      S_WAIT1:   state_d = S_WAIT2;
      S_WAIT2:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = (avail != '0) ? S_ISSUE : S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register with outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issue_q     <= '0;
      ce_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_q     <= (state_d == S_ISSUE) ? head_next : '0;
      ce_q        <= (state_d == S_ISSUE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      res_valid_q <= (state_d == S_CAPTURE);
      if (state_d == S_CAPTURE) res_data_q <= cpu_data_out;
    end
  end

  assign prog_full   = full;
  assign prog_count  = count_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cpu_ce      = ce_q;
  assign cpu_load    = issue_q[17];
  assign cpu_cin     = issue_q[16];
  assign cpu_cout    = issue_q[15];
  assign cpu_opcode  = issue_q[14:8];
  assign cpu_data_in = issue_q[7:0];
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;

endmodule
